// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM shared memory bus arbiter with starvation guard
// Optional perf counters when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wmask,
    output logic                mem_gnt,
    output logic                mem_rvalid,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wmask,
    input  logic                bus_ready,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stall_if,
    output logic                stall_mem
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_if_grants,
    output logic [31:0]         perf_mem_grants,
    output logic [31:0]         perf_conflicts
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

    state_t             state, nextState;
    owner_t             owner;
    logic [CNT_W-1:0]   starveCnt;
    logic               starveFull;
    logic               grantIf, grantMem;
    logic               respValid;

    assign starveFull = (starveCnt == CNT_W'(STARVE_MAX));

    always_comb begin
        nextState = state;
        grantIf   = 1'b0;
        grantMem  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !(if_req && starveFull)) begin
                    grantMem  = 1'b1;
                    nextState = ISSUE;
                end else if (if_req) begin
                    grantIf   = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                if (bus_ready) begin
                    nextState = bus_rvalid ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // A response only counts once the memory has accepted the request.
    assign respValid  = bus_rvalid && ((state == ISSUE && bus_ready) || state == WAIT);
    assign if_gnt     = grantIf;
    assign mem_gnt    = grantMem;
    assign if_rvalid  = respValid && (owner == OWN_IF);
    assign mem_rvalid = respValid && (owner == OWN_MEM);
    assign if_rdata   = if_rvalid  ? bus_rdata : '0;
    assign mem_rdata  = mem_rvalid ? bus_rdata : '0;
    assign bus_req    = (state == ISSUE);
    assign stall_if   = if_req  && !if_rvalid;
    assign stall_mem  = mem_req && !mem_rvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wmask <= '0;
        end else begin
            state <= nextState;
            if (grantMem) begin
                owner     <= OWN_MEM;
                bus_we    <= mem_we;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
                bus_wmask <= mem_wmask;
            end else if (grantIf) begin
                owner     <= OWN_IF;
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
                bus_wmask <= '0;
            end else if (state != IDLE && nextState == IDLE) begin
                owner <= OWN_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt <= '0;
        end else if (grantIf) begin
            starveCnt <= '0;
        end else if (grantMem && if_req && !starveFull) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_grants  <= '0;
            perf_mem_grants <= '0;
            perf_conflicts  <= '0;
        end else begin
            if (grantIf)  perf_if_grants  <= perf_if_grants + 32'd1;
            if (grantMem) perf_mem_grants <= perf_mem_grants + 32'd1;
            if (state == IDLE && if_req && mem_req) perf_conflicts <= perf_conflicts + 32'd1;
        end
    end
`endif

    // Protocol checks: stray responses and requests withdrawn before their grant.
    a_stray_rvalid: assert property (@(posedge clk) disable iff (!rst)
        !(bus_rvalid && !respValid));
    a_if_req_held: assert property (@(posedge clk) disable iff (!rst)
        (if_req && !if_gnt) |=> if_req);
    a_mem_req_held: assert property (@(posedge clk) disable iff (!rst)
        (mem_req && !mem_gnt) |=> mem_req);

endmodule
